// File: rtl/tt_spine_sel_pkg.sv
// Shared types and field helpers for the spine select controller.
package tt_spine_sel_pkg;

    localparam int BR_W  = 4;
    localparam int BLK_W = 5;
    localparam int SEL_W = BR_W + BLK_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    function automatic logic [BR_W-1:0] sel_branch(input logic [SEL_W-1:0] sel);
        return sel[SEL_W-1:BLK_W];
    endfunction

    function automatic logic [BLK_W-1:0] sel_block(input logic [SEL_W-1:0] sel);
        return sel[BLK_W-1:0];
    endfunction

endpackage

// File: rtl/tt_spine_sel_timer.sv
// Loadable 4-bit down-counter that times the settle phases; holds at zero.
module tt_spine_sel_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (clr_i) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/tt_spine_sel_ctrl.sv
// Break-before-make select/enable driver for the vertical spine row muxes.
// Optional TT_SPINE_SEL_CTRL_INC_EN adds an 'inc' pulse that steps to the next address.
module tt_spine_sel_ctrl
    import tt_spine_sel_pkg::*;
#(
    parameter int N_BRANCH   = 16,
    parameter int N_UM       = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [8:0] req_addr,
    input  logic       req_ena,
    input  logic       kill,
`ifdef TT_SPINE_SEL_CTRL_INC_EN
    input  logic       inc,
`endif
    output logic [8:0] spine_sel,
    output logic       spine_ena,
    output logic       busy,
    output logic       err
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic             ena_q;
    logic             err_q;
    logic [SEL_W-1:0] pend_addr_q;
    logic             pend_ena_q;

    logic             accept;
    logic             req_ok;
    logic             req_same;
    logic             start_d;
    logic [SEL_W-1:0] start_addr_d;
    logic             start_ena_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;

    assign req_ready = (state_q == ST_IDLE) && !kill;
    assign accept    = req_valid && req_ready;
    assign req_ok    = ({1'b0, sel_branch(req_addr)} < 5'(N_BRANCH)) &&
                       ({1'b0, sel_block(req_addr)}  < 6'(N_UM));
    assign req_same  = (req_addr == sel_q);

`ifdef TT_SPINE_SEL_CTRL_INC_EN
    logic [SEL_W-1:0] next_addr;
    logic [BLK_W:0]   blk_inc;
    logic [BR_W:0]    br_inc;

    // Row-major walk: block wraps into the next branch, branch wraps to 0.
    always_comb begin
        blk_inc   = {1'b0, sel_block(sel_q)} + 6'd1;
        br_inc    = {1'b0, sel_branch(sel_q)} + 5'd1;
        next_addr = {sel_branch(sel_q), blk_inc[BLK_W-1:0]};
        if (blk_inc == 6'(N_UM)) begin
            next_addr = {(br_inc == 5'(N_BRANCH)) ? {BR_W{1'b0}} : br_inc[BR_W-1:0],
                         {BLK_W{1'b0}}};
        end
    end
`endif

    // A real switch starts from IDLE either on a valid new address or on inc.
    always_comb begin
        start_d      = 1'b0;
        start_addr_d = req_addr;
        start_ena_d  = req_ena;
        if (accept) begin
            start_d = req_ok && !req_same;
        end
`ifdef TT_SPINE_SEL_CTRL_INC_EN
        else if (inc && req_ready) begin
            start_d      = 1'b1;
            start_addr_d = next_addr;
            start_ena_d  = ena_q;
        end
`endif
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (!kill) begin
            tmr_load = start_d || ((state_q == ST_DRAIN) && tmr_zero);
            tmr_dec  = (state_q != ST_IDLE) && !tmr_zero;
        end
    end

    tt_spine_sel_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (kill),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            ena_q       <= 1'b0;
            err_q       <= 1'b0;
            pend_addr_q <= '0;
            pend_ena_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (kill) begin
                state_q     <= ST_IDLE;
                ena_q       <= 1'b0;
                pend_addr_q <= '0;
                pend_ena_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept && !req_ok) begin
                            err_q <= 1'b1;
                        end else if (accept && req_same) begin
                            ena_q <= req_ena;
                        end else if (start_d) begin
                            ena_q       <= 1'b0;
                            pend_addr_q <= start_addr_d;
                            pend_ena_q  <= start_ena_d;
                            state_q     <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (tmr_zero) begin
                            sel_q   <= pend_addr_q;
                            state_q <= ST_SWITCH;
                        end
                    end
                    ST_SWITCH: begin
                        if (tmr_zero) begin
                            ena_q   <= pend_ena_q;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign spine_sel = sel_q;
    assign spine_ena = ena_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_tt_spine_sel_ctrl.sv
// Scoreboard bench for tt_spine_sel_ctrl: expected outputs queued at drive time, checked after each edge.
module tb_tt_spine_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [8:0] req_addr;
    logic       req_ena;
    logic       kill;
    logic [8:0] spine_sel;
    logic       spine_ena;
    logic       busy;
    logic       err;
`ifdef TT_SPINE_SEL_CTRL_INC_EN
    logic       inc;
    logic       inc_nxt;
`endif

    int n_tot  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [8:0] sel;
        logic       ena;
        logic       busy;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] prev_sel = 9'h000;

    always #5 clk = ~clk;

    tt_spine_sel_ctrl #(
        .N_BRANCH   (16),
        .N_UM       (16),
        .SETTLE_CYC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_ena   (req_ena),
        .kill      (kill),
`ifdef TT_SPINE_SEL_CTRL_INC_EN
        .inc       (inc),
`endif
        .spine_sel (spine_sel),
        .spine_ena (spine_ena),
        .busy      (busy),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus at negedge; queue what must be visible after the next posedge.
    task automatic cyc(input string tag, input logic v, input logic [8:0] a, input logic e,
                       input logic k, input logic [8:0] xs, input logic xe, input logic xb,
                       input logic xerr, input logic xr);
        exp_t x;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        req_ena   = e;
        kill      = k;
`ifdef TT_SPINE_SEL_CTRL_INC_EN
        inc     = inc_nxt;
        inc_nxt = 1'b0;
`endif
        x.tag = tag; x.sel = xs; x.ena = xe; x.busy = xb; x.err = xerr; x.rdy = xr;
        sb_q.push_back(x);
    endtask

    task automatic idle(input string tag, input logic [8:0] xs, input logic xe, input logic xb,
                        input logic xr);
        cyc(tag, 1'b0, 9'h000, 1'b0, 1'b0, xs, xe, xb, 1'b0, xr);
    endtask

    // Full break-before-make switch from old_sel (currently enabled or not) to addr.
    task automatic sw_seq(input string tag, input logic [8:0] old_sel, input logic [8:0] addr,
                          input logic e);
        cyc({tag, "_acc"}, 1'b1, addr, e, 1'b0, old_sel, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) idle({tag, "_drain"}, old_sel, 1'b0, 1'b1, 1'b0);
        idle({tag, "_sel"}, addr, 1'b0, 1'b1, 1'b0);
        repeat (3) idle({tag, "_switch"}, addr, 1'b0, 1'b1, 1'b0);
        idle({tag, "_ena"}, addr, e, 1'b0, 1'b1);
    endtask

    always begin
        exp_t x;
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk({x.tag, ".sel"},  32'(spine_sel), 32'(x.sel));
            chk({x.tag, ".ena"},  32'(spine_ena), 32'(x.ena));
            chk({x.tag, ".busy"}, 32'(busy),      32'(x.busy));
            chk({x.tag, ".err"},  32'(err),       32'(x.err));
            chk({x.tag, ".rdy"},  32'(req_ready), 32'(x.rdy));
        end
        if (spine_sel !== prev_sel) chk("bbm_ena_low", 32'(spine_ena), 32'd0);
        prev_sel = spine_sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 9'h000; req_ena = 1'b0; kill = 1'b0;
`ifdef TT_SPINE_SEL_CTRL_INC_EN
        inc = 1'b0; inc_nxt = 1'b0;
`endif
        #23;
        chk("rst.sel",  32'(spine_sel), 32'h000);
        chk("rst.ena",  32'(spine_ena), 32'd0);
        chk("rst.busy", 32'(busy),      32'd0);
        chk("rst.err",  32'(err),       32'd0);
        chk("rst.rdy",  32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Full switch to 0x023, with a different request ignored while busy.
        cyc("t1_acc", 1'b1, 9'h023, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("t1_ign", 1'b1, 9'h0AA, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) idle("t1_drain", 9'h000, 1'b0, 1'b1, 1'b0);
        idle("t1_sel", 9'h023, 1'b0, 1'b1, 1'b0);
        repeat (3) idle("t1_switch", 9'h023, 1'b0, 1'b1, 1'b0);
        idle("t1_ena", 9'h023, 1'b1, 1'b0, 1'b1);

        // Same address: enable follows in one cycle, never busy.
        cyc("t2_off", 1'b1, 9'h023, 1'b0, 1'b0, 9'h023, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("t2_idle", 9'h023, 1'b0, 1'b0, 1'b1);
        cyc("t2_on", 1'b1, 9'h023, 1'b1, 1'b0, 9'h023, 1'b1, 1'b0, 1'b0, 1'b1);

        // Invalid block indices: err pulse, nothing else moves.
        cyc("t3_inv16", 1'b1, 9'h010, 1'b0, 1'b0, 9'h023, 1'b1, 1'b0, 1'b1, 1'b1);
        idle("t3_clr", 9'h023, 1'b1, 1'b0, 1'b1);
        cyc("t3_inv31", 1'b1, 9'h1FF, 1'b0, 1'b0, 9'h023, 1'b1, 1'b0, 1'b1, 1'b1);
        idle("t3_clr2", 9'h023, 1'b1, 1'b0, 1'b1);

        // kill during DRAIN with a competing request: old select kept, pending dropped.
        cyc("t4_acc", 1'b1, 9'h045, 1'b1, 1'b0, 9'h023, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("t4_d1", 9'h023, 1'b0, 1'b1, 1'b0);
        cyc("t4_kill", 1'b1, 9'h067, 1'b1, 1'b1, 9'h023, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) idle("t4_hold", 9'h023, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of SWITCH.
        cyc("t5_acc", 1'b1, 9'h100, 1'b1, 1'b0, 9'h023, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) idle("t5_drain", 9'h023, 1'b0, 1'b1, 1'b0);
        idle("t5_sel", 9'h100, 1'b0, 1'b1, 1'b0);
        repeat (2) idle("t5_switch", 9'h100, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst.sel",  32'(spine_sel), 32'h000);
        chk("t5_rst.ena",  32'(spine_ena), 32'd0);
        chk("t5_rst.busy", 32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) idle("t5_lost", 9'h000, 1'b0, 1'b0, 1'b1);

`ifdef TT_SPINE_SEL_CTRL_INC_EN
        // inc from the last valid address wraps to 0x000 and keeps the enable.
        sw_seq("t6_set", 9'h000, 9'h1EF, 1'b1);
        inc_nxt = 1'b1;
        idle("t6_inc", 9'h1EF, 1'b0, 1'b1, 1'b0);
        repeat (3) idle("t6_drain", 9'h1EF, 1'b0, 1'b1, 1'b0);
        idle("t6_sel", 9'h000, 1'b0, 1'b1, 1'b0);
        repeat (3) idle("t6_switch", 9'h000, 1'b0, 1'b1, 1'b0);
        idle("t6_ena", 9'h000, 1'b1, 1'b0, 1'b1);
`endif

        // One more ordinary switch to a high branch to cover the top address bits.
        sw_seq("t7", 9'h000, 9'h1C7, 1'b1);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/tt_spine_sel_ctrl.md
Name: tt_spine_sel_ctrl

Overview:
- Spine-side controller that drives the 9-bit select field and the enable strobe consumed by every row mux on the vertical spine.
- Select layout: [8:5] branch address, [4:0] block index within the row pair.
- Applies each selection change break-before-make: deassert enable, wait, change the select, wait, re-enable. This keeps two user modules from ever being enabled on the spine at once.
- Sits between the chip control logic (request source) and the spine input bus.

Parameters:
- N_BRANCH, 16, number of valid branch addresses (max 16).
- N_UM, 16, number of valid block indices per branch (max 32).
- SETTLE_CYC, 4, cycles held in each settle phase (range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  selection request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  9  requested select, {branch[3:0], block[4:0]}
- req_ena  in  1  requested enable state after the switch
- kill  in  1  synchronous force-off
- spine_sel  out  9  select driven onto the spine (registered)
- spine_ena  out  1  enable driven onto the spine (registered)
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse when an invalid request is consumed

Behaviour:
- Reset (async, rst_n low): state=IDLE, spine_sel=0, spine_ena=0, err=0, timer=0. Release is synchronous to clk.
- States: IDLE, DRAIN, SWITCH.
- req_ready = (state==IDLE) & !kill. A request is accepted on the edge where req_valid & req_ready.
- Invalid request: req_addr[8:5] >= N_BRANCH or req_addr[4:0] >= N_UM.
  - Request is consumed; err pulses on the next cycle.
  - spine_sel, spine_ena and state are unchanged.
- Same-address request (req_addr == spine_sel):
  - spine_ena <= req_ena on the accept edge; state stays IDLE.
  - Effective latency is 1 cycle.
- New address, accept edge k:
  - spine_ena <= 0, pending {addr, ena} latched, timer <= SETTLE_CYC-1, state <= DRAIN.
- DRAIN:
  - Timer decrements each cycle.
  - On the edge where timer==0: spine_sel <= pending addr, timer <= SETTLE_CYC-1, state <= SWITCH.
- SWITCH:
  - Timer decrements each cycle.
  - On the edge where timer==0: spine_ena <= pending ena, state <= IDLE.
- Timing: spine_sel changes at edge k+SETTLE_CYC; spine_ena rises at edge k+2*SETTLE_CYC. req_ready is high again in the following cycle.
- Invariant: spine_ena is 0 on every cycle where spine_sel differs from its value on the previous cycle.
- kill (any state):
  - Next edge: spine_ena <= 0, state <= IDLE, timer cleared, pending request discarded.
  - spine_sel keeps its current value. If kill arrives in DRAIN, spine_sel keeps the old address.
  - kill beats a simultaneous req_valid because req_ready is low.
- req_valid while busy: ignored (req_ready=0). The requester holds the request until ready.
- Reset mid-switch: immediate return to reset values; the pending request is lost.

Optional Feature:
- Macro: TT_SPINE_SEL_CTRL_INC_EN.
- With the macro: adds input inc (1-bit pulse).
  - In IDLE with req_valid low and kill low, inc starts a normal DRAIN/SWITCH sequence to the next address. The pending ena is the current spine_ena.
  - Next address: block+1; if block+1==N_UM, block=0 and branch+1; if branch+1==N_BRANCH, branch=0.
  - req_valid has priority over inc in the same cycle. inc while busy is ignored.
- Without the macro: no inc port and no increment logic.

Decomposition:
- Package tt_spine_sel_pkg:
  - State enum (IDLE, DRAIN, SWITCH).
  - Constants BR_W=4, BLK_W=5, SEL_W=9.
  - Field-extract helpers for branch/block.
- Sub-module tt_spine_sel_timer: loadable 4-bit down-counter with load, dec and zero flag. Instantiated once.

Test Plan (SETTLE_CYC=4):
- Reset, then req {addr=9'h023, ena=1} accepted at edge 0 -> spine_ena=0 at edge 0; spine_sel=0x023 at edge 4; spine_ena=1 at edge 8; busy high for 8 cycles.
- From sel=0x023, ena=1: req {addr=0x023, ena=0} -> spine_ena=0 on the next edge, busy never asserts.
- req addr block=16 with N_UM=16 -> err pulses 1 cycle, spine_sel/spine_ena unchanged, req_ready stays 1.
- kill at cycle 2 of DRAIN -> spine_ena=0, spine_sel keeps old value, IDLE next cycle; req_valid asserted with kill -> not accepted.
- rst_n asserted mid-SWITCH -> spine_sel=0 and spine_ena=0 asynchronously; request lost after release.
- With TT_SPINE_SEL_CTRL_INC_EN, from sel={br=15, blk=15}: inc -> spine_sel=0x000 after 4 cycles; enable state preserved.
